// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types for the RVX10 hazard unit.
// Forward-select encoding, controller states and register index type.
package hazard_pkg;

  typedef logic [4:0] regidx_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN  = 1'b0,
    BUSY = 1'b1
  } hz_state_t;

  function automatic fwd_sel_t fwd_sel(
    input regidx_t rs,
    input logic    wm,
    input regidx_t rdm,
    input logic    ww,
    input regidx_t rdw
  );
    fwd_sel_t s;
    s = FWD_RF;
    if (wm && rdm != '0 && rdm == rs)
      s = FWD_M;
    else if (ww && rdw != '0 && rdw == rs)
      s = FWD_W;
    return s;
  endfunction

endpackage

// File: rtl/hazard_perf_ctr.sv
// hazard_perf_ctr: 32-bit saturating event counter with enable.
// Holds at all-ones once full.
module hazard_perf_ctr
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  output logic [31:0] cnt
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt <= '0;
    else if (en && cnt != 32'hFFFF_FFFF)
      cnt <= cnt + 32'd1;
  end

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush/forward control for the RVX10 5-stage core.
// Define HAZARD_PERF_EN to add the PerfLdStall/PerfFlush/PerfBusy counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MAX_BUSY = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        ResultSrcE0,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        PCSrcE,
  input  logic        MulStartE,
  input  logic        MulDoneE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushM,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
`ifdef HAZARD_PERF_EN
  output logic [31:0] PerfLdStall,
  output logic [31:0] PerfFlush,
  output logic [31:0] PerfBusy,
`endif
  output logic        TimeoutErr
);

  localparam logic [7:0] BUSY_LAST = 8'(MAX_BUSY - 1);

  hz_state_t  state_q, state_d;
  logic [7:0] busy_cnt, cnt_d;
  logic       to_set;
  logic       lw_stall;

  assign lw_stall = ResultSrcE0 && RdE != '0 &&
                    (RdE == Rs1D || RdE == Rs2D);

  assign ForwardAE = reset_n ?
    fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW) : FWD_RF;
  assign ForwardBE = reset_n ?
    fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW) : FWD_RF;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RUN;
      busy_cnt   <= '0;
      TimeoutErr <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_cnt <= cnt_d;
      if (to_set)
        TimeoutErr <= 1'b1;
    end
  end

  always_comb begin
    StallF  = 1'b0;
    StallD  = 1'b0;
    StallE  = 1'b0;
    FlushD  = 1'b0;
    FlushE  = 1'b0;
    FlushM  = 1'b0;
    state_d = state_q;
    cnt_d   = busy_cnt;
    to_set  = 1'b0;
    if (!reset_n) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushM = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (MulStartE && !MulDoneE) begin
            StallF  = 1'b1;
            StallD  = 1'b1;
            StallE  = 1'b1;
            FlushM  = 1'b1;
            state_d = BUSY;
            cnt_d   = '0;
          end else if (!MulStartE) begin
            StallF = lw_stall;
            StallD = lw_stall;
            FlushE = lw_stall || PCSrcE;
            FlushD = PCSrcE;
          end
        end
        BUSY: begin
          if (MulDoneE) begin
            state_d = RUN;
          end else if (busy_cnt == BUSY_LAST) begin
            // watchdog: drop the stall and give EX back to the pipe
            to_set  = 1'b1;
            state_d = RUN;
          end else begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
            cnt_d  = busy_cnt + 8'd1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  hazard_perf_ctr u_ld (
    .clk(clk), .reset_n(reset_n),
    .en(state_q == RUN && lw_stall),
    .cnt(PerfLdStall)
  );
  hazard_perf_ctr u_fl (
    .clk(clk), .reset_n(reset_n),
    .en(state_q == RUN && PCSrcE),
    .cnt(PerfFlush)
  );
  hazard_perf_ctr u_bz (
    .clk(clk), .reset_n(reset_n),
    .en(StallE),
    .cnt(PerfBusy)
  );
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed vectors for hazard_unit with MAX_BUSY=4.
// Inputs change 1 time unit after each rising edge; checks follow 1 unit later.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       ResultSrcE0, RegWriteM, RegWriteW;
  logic       PCSrcE, MulStartE, MulDoneE;
  logic       StallF, StallD, StallE;
  logic       FlushD, FlushE, FlushM;
  logic [1:0] ForwardAE, ForwardBE;
  logic       TimeoutErr;
`ifdef HAZARD_PERF_EN
  logic [31:0] PerfLdStall, PerfFlush, PerfBusy;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_unit #(.MAX_BUSY(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW),
    .ResultSrcE0(ResultSrcE0),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE),
    .MulStartE(MulStartE), .MulDoneE(MulDoneE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
`ifdef HAZARD_PERF_EN
    .PerfLdStall(PerfLdStall), .PerfFlush(PerfFlush),
    .PerfBusy(PerfBusy),
`endif
    .TimeoutErr(TimeoutErr)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0;
    RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE0 = 0; RegWriteM = 0; RegWriteW = 0;
    PCSrcE = 0; MulStartE = 0; MulDoneE = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {StallF,StallD,StallE,FlushD,FlushE,FlushM}
  function automatic logic [5:0] ctl();
    return {StallF, StallD, StallE, FlushD, FlushE, FlushM};
  endfunction

  int nstall;

  initial begin
    idle();
    reset_n = 1'b0;
    RegWriteM = 1; RdM = 3; Rs1E = 3;
    #3;
    chk("rst_ctl", ctl(), 6'b000111);
    chk("rst_fwdA", ForwardAE, 2'b00);
    chk("rst_to", TimeoutErr, 1'b0);
    tick(); tick();
    reset_n = 1'b1;
    idle();
    #1;
    chk("run_idle", ctl(), 6'b000000);

    // forwarding
    tick();
    RegWriteM = 1; RdM = 5; RegWriteW = 1; RdW = 5;
    Rs1E = 5; Rs2E = 0;
    #1;
    chk("fwdA_mem", ForwardAE, 2'b10);
    chk("fwdB_x0", ForwardBE, 2'b00);
    RegWriteM = 0;
    #1;
    chk("fwdA_wb", ForwardAE, 2'b01);
    RdW = 0; Rs1E = 0;
    #1;
    chk("fwd_x0", ForwardAE, 2'b00);
    RegWriteM = 1; RdM = 9; Rs2E = 9;
    RegWriteW = 1; RdW = 4; Rs1E = 4;
    #1;
    chk("fwdB_mem", ForwardBE, 2'b10);
    chk("fwdA_wb2", ForwardAE, 2'b01);

    // load-use
    tick(); idle();
    ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
    #1;
    chk("lw_stall", ctl(), 6'b110010);
    tick(); idle();
    #1;
    chk("lw_bubble", ctl(), 6'b000000);
    ResultSrcE0 = 1; RdE = 0; Rs1D = 0;
    #1;
    chk("lw_x0", ctl(), 6'b000000);

    // branch
    tick(); idle();
    PCSrcE = 1;
    #1;
    chk("br", ctl(), 6'b000110);
    ResultSrcE0 = 1; RdE = 6; Rs1D = 6;
    #1;
    chk("br_lw", ctl(), 6'b110110);

    // multi-cycle op, done after 4 cycles
    tick(); idle();
    MulStartE = 1;
    #1;
    chk("mul_t", ctl(), 6'b111001);
    for (int i = 1; i <= 3; i++) begin
      tick(); idle();
      PCSrcE = 1;
      #1;
      chk($sformatf("mul_t%0d", i), ctl(), 6'b111001);
    end
    tick(); idle();
    MulDoneE = 1;
    #1;
    chk("mul_done", ctl(), 6'b000000);
    tick(); idle();
    #1;
    chk("mul_run", ctl(), 6'b000000);
    chk("mul_noto", TimeoutErr, 1'b0);
    MulStartE = 1; MulDoneE = 1;
    #1;
    chk("mul_1cyc", ctl(), 6'b000000);
    tick(); idle();
    #1;
    chk("mul_1cyc_run", ctl(), 6'b000000);

`ifdef HAZARD_PERF_EN
    chk("perf_busy", PerfBusy, 32'd4);
`endif

    // watchdog
    idle();
    MulStartE = 1;
    nstall = 0;
    #1;
    if (StallE) nstall++;
    for (int i = 0; i < 6; i++) begin
      tick(); idle();
      #1;
      if (StallE) nstall++;
    end
    chk("wd_stalls", nstall, 4);
    chk("wd_to", TimeoutErr, 1'b1);
    chk("wd_ctl", ctl(), 6'b000000);

    // reset in BUSY
    tick(); idle();
    MulStartE = 1;
    tick(); idle();
    #1;
    chk("rb_busy", ctl(), 6'b111001);
    RegWriteM = 1; RdM = 2; Rs1E = 2;
    reset_n = 1'b0;
    #1;
    chk("rb_ctl", ctl(), 6'b000111);
    chk("rb_fwd", ForwardAE, 2'b00);
    chk("rb_to", TimeoutErr, 1'b0);
`ifdef HAZARD_PERF_EN
    chk("rb_perf", PerfLdStall | PerfFlush | PerfBusy, 32'd0);
`endif
    tick();
    reset_n = 1'b1;
    idle();
    tick();
    #1;
    chk("rb_run", ctl(), 6'b000000);
    chk("rb_to2", TimeoutErr, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
